reg_bus_rr_mux: RTL and testbench
=================================

Name: reg_bus_rr_mux

Overview:
N-to-1 register bus multiplexer: NUM_PORTS register bus masters share one register bus slave. Round-robin arbitration; grant is registered and held until the slave completes the transaction. Extends the single-phase register bus (addr/write/wdata/wstrb/valid in; rdata/error/ready out) to multiple channels and arbitrary widths. Sits between CPU/debug/DMA config masters and a peripheral register file.

Parameters:
NUM_PORTS, 4, number of master ports (>=1)
ADDR_WIDTH, 32, address width in bits
DATA_WIDTH, 32, data width in bits (multiple of 8); strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 256, watchdog limit in BUSY cycles (used only with the optional feature, >=2)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
in_addr_i  input  NUM_PORTS*ADDR_WIDTH  per-port address, port p at slice p
in_write_i  input  NUM_PORTS  per-port 1=write, 0=read
in_wdata_i  input  NUM_PORTS*DATA_WIDTH  per-port write data
in_wstrb_i  input  NUM_PORTS*DATA_WIDTH/8  per-port byte strobes
in_valid_i  input  NUM_PORTS  per-port request valid
in_rdata_o  output  NUM_PORTS*DATA_WIDTH  per-port read data
in_error_o  output  NUM_PORTS  per-port error
in_ready_o  output  NUM_PORTS  per-port completion
out_addr_o  output  ADDR_WIDTH  slave address
out_write_o  output  1  slave write
out_wdata_o  output  DATA_WIDTH  slave write data
out_wstrb_o  output  DATA_WIDTH/8  slave strobes
out_valid_o  output  1  slave valid
out_rdata_i  input  DATA_WIDTH  slave read data
out_error_i  input  1  slave error
out_ready_i  input  1  slave completion

Behaviour:
- Reset (synchronous, rst_i=1 at edge): state IDLE, grant index 0, RR pointer 0, watchdog 0. All outputs 0 while in IDLE.
- FSM states IDLE, BUSY.
- IDLE: if any in_valid_i set, select first set bit at or above RR pointer, wrapping modulo NUM_PORTS; register index into grant; go BUSY next cycle. No valid: stay IDLE.
- BUSY: out_addr/write/wdata/wstrb = granted port's inputs (combinational); out_valid_o = in_valid_i[grant].
- Completion: out_valid_o & out_ready_i in same cycle -> in_ready_o[grant]=1, in_rdata_o[grant]=out_rdata_i, in_error_o[grant]=out_error_i, all combinational; next state IDLE; RR pointer = (grant+1) mod NUM_PORTS.
- Non-granted ports: ready, error, rdata always 0. Granted port rdata/error are 0 when not completing.
- Latency: 1 arbitration cycle; zero-wait slave gives 2 cycles/transaction; at most one transaction per 2 cycles.
- Illegal drop of in_valid_i[grant] during BUSY: return to IDLE next cycle, no completion, RR pointer unchanged.
- Requests arriving during BUSY wait; valid never depends on ready.
- NUM_PORTS=1: grant always 0, same 2-cycle FSM. Grant/pointer width max(1,$clog2(NUM_PORTS)).
- Reset mid-BUSY: transaction abandoned; out_valid_o and in_ready_o are 0 from the cycle after the reset edge.

Optional Feature:
REG_BUS_RR_MUX_TIMEOUT_EN. Defined: watchdog counts BUSY cycles, cleared on entering BUSY. On BUSY cycle number TIMEOUT_CYCLES with no out_ready_i: in_ready_o[grant]=1, in_error_o[grant]=1, in_rdata_o[grant]=0; go IDLE; advance RR pointer; out_valid_o drops next cycle. Slave completion in that same cycle takes priority. Undefined: no counter, BUSY waits indefinitely.

Test Plan:
- Port 2 write addr 0x40, wdata 0x1234, slave ready 3 cycles after out_valid -> out_valid_o rises cycle 1, in_ready_o[2] pulses cycle 4, out_addr_o=0x40, ports 0/1/3 ready stay 0.
- All 4 ports valid after reset, zero-wait slave -> grants 0,1,2,3 in order, in_ready_o pulses at cycles 1,3,5,7.
- Ports 0 and 3 continuously valid -> grant sequence 0,3,0,3; never two consecutive grants to the same port.
- Port 1 read, slave returns rdata 0xDEADBEEF, error 1 -> in_rdata_o[1]=0xDEADBEEF, in_error_o[1]=1; other ports' rdata 0.
- rst_i asserted in BUSY cycle 2 -> next cycle out_valid_o=0, all outputs 0; next request from port 3 with ports 0,3 valid grants port 0.
- Macro defined, TIMEOUT_CYCLES=8, slave never ready -> in_ready_o[grant]=1, in_error_o=1 on BUSY cycle 8; out_valid_o=0 the cycle after.

Source files
------------

// File: rtl/reg_bus_rr_mux.sv
// N-to-1 register bus multiplexer with round-robin arbitration and a registered grant.
// Optional BUSY watchdog enabled by defining REG_BUS_RR_MUX_TIMEOUT_EN.
module reg_bus_rr_mux #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     in_addr_i,
    input  logic [NUM_PORTS-1:0]                in_write_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     in_wdata_i,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] in_wstrb_i,
    input  logic [NUM_PORTS-1:0]                in_valid_i,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]     in_rdata_o,
    output logic [NUM_PORTS-1:0]                in_error_o,
    output logic [NUM_PORTS-1:0]                in_ready_o,
    output logic [ADDR_WIDTH-1:0]               out_addr_o,
    output logic                                out_write_o,
    output logic [DATA_WIDTH-1:0]               out_wdata_o,
    output logic [DATA_WIDTH/8-1:0]             out_wstrb_o,
    output logic                                out_valid_o,
    input  logic [DATA_WIDTH-1:0]               out_rdata_i,
    input  logic                                out_error_i,
    input  logic                                out_ready_i
);

    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if (NUM_PORTS < 1 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("reg_bus_rr_mux: illegal parameter combination");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] pick;
    logic [GW-1:0] grant_inc;
    logic          busy;
    logic          gnt_valid;
    logic          complete;
    logic          timeout;

    assign busy      = (state_q == BUSY);
    assign gnt_valid = in_valid_i[grant_q];
    assign complete  = busy && gnt_valid && out_ready_i;
    assign grant_inc = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

`ifdef REG_BUS_RR_MUX_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES);

    logic [WW-1:0] wdog_q, wdog_d;

    // Counts completed BUSY cycles; zero on the first BUSY cycle of every transaction.
    assign wdog_d  = (busy && state_d == BUSY) ? wdog_q + 1'b1 : '0;
    assign timeout = busy && gnt_valid && !out_ready_i && (wdog_q == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        pick = '0;
        for (int unsigned i = NUM_PORTS; i > 0; i--) begin
            // Walk downward so the lowest offset from the pointer wins.
            int unsigned idx;
            idx = (32'(ptr_q) + i - 1) % NUM_PORTS;
            if (in_valid_i[idx]) begin
                pick = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|in_valid_i) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (complete || timeout) begin
                    state_d = IDLE;
                    ptr_d   = grant_inc;
                end else if (!gnt_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        out_addr_o  = '0;
        out_write_o = 1'b0;
        out_wdata_o = '0;
        out_wstrb_o = '0;
        out_valid_o = 1'b0;
        in_rdata_o  = '0;
        in_error_o  = '0;
        in_ready_o  = '0;
        if (busy) begin
            out_addr_o  = in_addr_i[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
            out_write_o = in_write_i[grant_q];
            out_wdata_o = in_wdata_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            out_wstrb_o = in_wstrb_i[int'(grant_q)*SW +: SW];
            out_valid_o = gnt_valid;
        end
        if (complete) begin
            in_ready_o[grant_q]                              = 1'b1;
            in_error_o[grant_q]                              = out_error_i;
            in_rdata_o[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = out_rdata_i;
        end else if (timeout) begin
            in_ready_o[grant_q] = 1'b1;
            in_error_o[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_bus_rr_mux.sv
// Self-checking bench for reg_bus_rr_mux: cycle-by-cycle vector table plus directed
// sequences for reset-in-BUSY, illegal valid drop and (when enabled) the watchdog.
module tb_reg_bus_rr_mux;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [NP*AW-1:0]   in_addr;
    logic [NP-1:0]      in_write;
    logic [NP*DW-1:0]   in_wdata;
    logic [NP*DW/8-1:0] in_wstrb;
    logic [NP-1:0]      in_valid;
    logic [NP*DW-1:0]   in_rdata;
    logic [NP-1:0]      in_error;
    logic [NP-1:0]      in_ready;
    logic [AW-1:0]      out_addr;
    logic               out_write;
    logic [DW-1:0]      out_wdata;
    logic [DW/8-1:0]    out_wstrb;
    logic               out_valid;
    logic [DW-1:0]      out_rdata;
    logic               out_error;
    logic               out_ready;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    reg_bus_rr_mux #(
        .NUM_PORTS(NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .in_addr_i(in_addr),
        .in_write_i(in_write),
        .in_wdata_i(in_wdata),
        .in_wstrb_i(in_wstrb),
        .in_valid_i(in_valid),
        .in_rdata_o(in_rdata),
        .in_error_o(in_error),
        .in_ready_o(in_ready),
        .out_addr_o(out_addr),
        .out_write_o(out_write),
        .out_wdata_o(out_wdata),
        .out_wstrb_o(out_wstrb),
        .out_valid_o(out_valid),
        .out_rdata_i(out_rdata),
        .out_error_i(out_error),
        .out_ready_i(out_ready)
    );

    typedef struct {
        logic         rst;
        logic [3:0]   valid;
        logic         ordy;
        logic         oerr;
        logic [31:0]  ordata;
        logic         e_ovalid;
        logic [31:0]  e_oaddr;
        logic [3:0]   e_ready;
        logic [3:0]   e_error;
        logic [127:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [3:0] v, logic ordy, logic oerr, logic [31:0] ord,
                                logic eov, logic [31:0] ea, logic [3:0] er, logic [3:0] ee,
                                logic [127:0] erd);
        vec_t t;
        t.rst = r; t.valid = v; t.ordy = ordy; t.oerr = oerr; t.ordata = ord;
        t.e_ovalid = eov; t.e_oaddr = ea; t.e_ready = er; t.e_error = ee; t.e_rdata = erd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] RA = 32'h0000_0055;
    localparam logic [31:0] RB = 32'hA5A5_0000;
    localparam logic [31:0] RD = 32'hDEAD_BEEF;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Port p: addresses 0x10,0x20,0x40,0x30; only port 2 writes.
        in_addr   = {32'h30, 32'h40, 32'h20, 32'h10};
        in_wdata  = {32'hCCCC, 32'h1234, 32'hBBBB, 32'hAAAA};
        in_wstrb  = {4'hC, 4'hF, 4'h3, 4'h1};
        in_write  = 4'b0100;
        in_valid  = '0;
        out_rdata = '0;
        out_error = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Port 2 write, slave ready 3 cycles after out_valid; rdata/error masked until completion.
        vecs.push_back(mk(0, 4'b0100, 0, 0, RA, 0, 32'h0,  4'b0000, 4'b0000, '0));
        vecs.push_back(mk(0, 4'b0100, 0, 1, RA, 1, 32'h40, 4'b0000, 4'b0000, '0));
        vecs.push_back(mk(0, 4'b0100, 0, 1, RA, 1, 32'h40, 4'b0000, 4'b0000, '0));
        vecs.push_back(mk(0, 4'b0100, 0, 1, RA, 1, 32'h40, 4'b0000, 4'b0000, '0));
        vecs.push_back(mk(0, 4'b0100, 1, 0, RA, 1, 32'h40, 4'b0100, 4'b0000, {32'h0, RA, 64'h0}));
        vecs.push_back(mk(1, 4'b0000, 0, 0, RA, 0, 32'h0,  4'b0000, 4'b0000, '0));
        // All four valid after reset, zero-wait slave: grants 0,1,2,3.
        vecs.push_back(mk(0, 4'b1111, 1, 0, RB, 0, 32'h0,  4'b0000, 4'b0000, '0));
        vecs.push_back(mk(0, 4'b1111, 1, 0, RB, 1, 32'h10, 4'b0001, 4'b0000, {96'h0, RB}));
        vecs.push_back(mk(0, 4'b1111, 1, 0, RB, 0, 32'h0,  4'b0000, 4'b0000, '0));
        vecs.push_back(mk(0, 4'b1111, 1, 0, RB, 1, 32'h20, 4'b0010, 4'b0000, {64'h0, RB, 32'h0}));
        vecs.push_back(mk(0, 4'b1111, 1, 0, RB, 0, 32'h0,  4'b0000, 4'b0000, '0));
        vecs.push_back(mk(0, 4'b1111, 1, 0, RB, 1, 32'h40, 4'b0100, 4'b0000, {32'h0, RB, 64'h0}));
        vecs.push_back(mk(0, 4'b1111, 1, 0, RB, 0, 32'h0,  4'b0000, 4'b0000, '0));
        vecs.push_back(mk(0, 4'b1111, 1, 0, RB, 1, 32'h30, 4'b1000, 4'b0000, {RB, 96'h0}));
        // Ports 0 and 3 continuously valid: 0,3,0,3.
        for (int k = 0; k < 2; k++) begin
            vecs.push_back(mk(0, 4'b1001, 1, 0, RB, 0, 32'h0,  4'b0000, 4'b0000, '0));
            vecs.push_back(mk(0, 4'b1001, 1, 0, RB, 1, 32'h10, 4'b0001, 4'b0000, {96'h0, RB}));
            vecs.push_back(mk(0, 4'b1001, 1, 0, RB, 0, 32'h0,  4'b0000, 4'b0000, '0));
            vecs.push_back(mk(0, 4'b1001, 1, 0, RB, 1, 32'h30, 4'b1000, 4'b0000, {RB, 96'h0}));
        end
        vecs.push_back(mk(0, 4'b0000, 0, 0, RB, 0, 32'h0,  4'b0000, 4'b0000, '0));
        // Port 1 read with slave error.
        vecs.push_back(mk(0, 4'b0010, 0, 0, RD, 0, 32'h0,  4'b0000, 4'b0000, '0));
        vecs.push_back(mk(0, 4'b0010, 1, 1, RD, 1, 32'h20, 4'b0010, 4'b0010, {64'h0, RD, 32'h0}));
        vecs.push_back(mk(0, 4'b0000, 0, 0, RD, 0, 32'h0,  4'b0000, 4'b0000, '0));

        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].ordy;
            out_error = vecs[i].oerr;
            out_rdata = vecs[i].ordata;
            #1;
            chk($sformatf("v%0d out_valid", i), 128'(out_valid), 128'(vecs[i].e_ovalid));
            chk($sformatf("v%0d out_addr", i),  128'(out_addr),  128'(vecs[i].e_oaddr));
            chk($sformatf("v%0d in_ready", i),  128'(in_ready),  128'(vecs[i].e_ready));
            chk($sformatf("v%0d in_error", i),  128'(in_error),  128'(vecs[i].e_error));
            chk($sformatf("v%0d in_rdata", i),  in_rdata,        vecs[i].e_rdata);
            tick();
        end
        rst = 1'b0;

        // Reset during BUSY cycle 2 (pointer is 2, so ports 0,3 valid grants 3 first).
        out_ready = 1'b0; out_error = 1'b0; out_rdata = RA;
        in_valid  = 4'b1001;
        #1 chk("e0 idle out_valid", 128'(out_valid), 128'(0));
        tick();
        chk("e1 busy addr", 128'(out_addr), 128'(32'h30));
        chk("e1 busy valid", 128'(out_valid), 128'(1));
        tick();
        rst = 1'b1;
        #1 chk("e2 busy valid", 128'(out_valid), 128'(1));
        tick();
        rst = 1'b0;
        #1;
        chk("e3 post-reset valid", 128'(out_valid), 128'(0));
        chk("e3 post-reset ready", 128'(in_ready), 128'(0));
        chk("e3 post-reset addr", 128'(out_addr), 128'(0));
        tick();
        out_ready = 1'b1;
        #1;
        chk("e4 regrant addr", 128'(out_addr), 128'(32'h10));
        chk("e4 regrant ready", 128'(in_ready), 128'(4'b0001));
        tick();

        // Illegal drop of the granted valid: pointer stays at 1.
        in_valid = 4'b0100;
        #1 chk("f0 idle valid", 128'(out_valid), 128'(0));
        tick();
        chk("f1 wdata", 128'(out_wdata), 128'(32'h1234));
        chk("f1 write", 128'(out_write), 128'(1));
        chk("f1 wstrb", 128'(out_wstrb), 128'(4'hF));
        in_valid = 4'b0000;
        #1;
        chk("f1 drop valid", 128'(out_valid), 128'(0));
        chk("f1 drop ready", 128'(in_ready), 128'(0));
        tick();
        in_valid = 4'b1100;
        #1 chk("f2 idle valid", 128'(out_valid), 128'(0));
        tick();
        chk("f3 grant after drop", 128'(out_addr), 128'(32'h40));
        chk("f3 ready", 128'(in_ready), 128'(4'b0100));
        tick();
        in_valid = 4'b0000;
        out_ready = 1'b0;

`ifdef REG_BUS_RR_MUX_TIMEOUT_EN
        // Slave never ready: forced error completion on BUSY cycle 8.
        out_rdata = 32'h77;
        in_valid  = 4'b0001;
        #1 chk("t0 idle valid", 128'(out_valid), 128'(0));
        tick();
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("t%0d ready", k), 128'(in_ready), (k == 8) ? 128'(4'b0001) : 128'(0));
            chk($sformatf("t%0d error", k), 128'(in_error), (k == 8) ? 128'(4'b0001) : 128'(0));
            chk($sformatf("t%0d rdata", k), in_rdata, '0);
            tick();
        end
        chk("t9 valid dropped", 128'(out_valid), 128'(0));
        in_valid = 4'b0000;
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
